// File: rtl/pipe_stage_reg.sv
// Purpose : one pipeline stage as a two-entry skid buffer (main = head, skid = overflow).
// Latency : one cycle from input transfer to out_valid when empty; one transfer per cycle in steady state.
// Backpres: in_ready comes from registered state and flush only, so out_ready has no path to in_ready.
//
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream valid-ready handshake and payload
//   out_valid/out_ready/out_data  downstream valid-ready handshake and head payload
//   flush                  synchronous squash of both entries (wins over any input transfer)
//   clr_cnt                synchronous clear of both performance counters
//   stall_cnt, bubble_cnt  saturating counters of stalled and starved cycles
module pipe_stage_reg #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  word_t  main_q, main_nxt;
  word_t  skid_q, skid_nxt;
  cnt_t   stall_q, bubble_q;

  logic in_xfer;
  logic out_xfer;
  logic stall_inc;
  logic bubble_inc;

  // Handshake decode: only registered state and flush feed in_ready.
  assign out_valid = (state != EMPTY);
  assign out_data  = (state == EMPTY) ? NOP_DATA : main_q;
  assign in_ready  = (state != FULL) & ~flush;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= EMPTY;
      main_q <= NOP_DATA;
      skid_q <= NOP_DATA;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // Squash everything; a head word handshaked this same cycle is
      // still considered delivered downstream.
      state_nxt = EMPTY;
      main_nxt  = NOP_DATA;
      skid_nxt  = NOP_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_nxt = in_data;
          end else if (in_xfer) begin
            skid_nxt  = in_data;
            state_nxt = FULL;
          end else if (out_xfer) begin
            main_nxt  = NOP_DATA;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path matters.
          if (out_xfer) begin
            main_nxt  = skid_q;
            skid_nxt  = NOP_DATA;
            state_nxt = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = NOP_DATA;
          skid_nxt  = NOP_DATA;
        end
      endcase
    end
  end

  // Performance counters saturate at all-ones; clr_cnt beats an increment.
  assign stall_inc  = out_valid & ~out_ready & ~(&stall_q);
  assign bubble_inc = out_ready & ~out_valid & ~(&bubble_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (clr_cnt) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_inc) begin
        stall_q <= stall_q + cnt_t'(1);
      end
      if (bubble_inc) begin
        bubble_q <= bubble_q + cnt_t'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose : self-checking bench for pipe_stage_reg against a queue-based reference model.
// Latency : model mirrors the stage contents as a FIFO of at most two words.
// Backpres: random in_valid/out_ready/flush/clr_cnt after directed scenarios.
module tb_pipe_stage_reg;

  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'hDEAD_BEEF;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              CLK;
  logic              nRST;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              clr_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: stage contents as an ordered queue plus counters.
  logic [31:0] mq[$];
  int          m_stall  = 0;
  int          m_bubble = 0;

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .NOP_DATA(NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Compare process: outputs are stable at the falling edge; check them
  // against the model, then advance the model with this cycle's inputs.
  always @(negedge CLK) begin
    if (!nRST) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, NOP);
      chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
      chk("rst_bubble", {28'd0, bubble_cnt}, 32'd0);
    end else begin
      logic        e_v, e_r, ix, ox;
      logic [31:0] e_d;
      e_v = (mq.size() > 0);
      e_d = e_v ? mq[0] : NOP;
      e_r = (mq.size() < 2) && !flush;
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_v});
      chk("out_data", out_data, e_d);
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_r});
      chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
      chk("bubble_cnt", {28'd0, bubble_cnt}, m_bubble);
      ix = in_valid && e_r;
      ox = e_v && out_ready;
      if (clr_cnt) begin
        m_stall  = 0;
        m_bubble = 0;
      end else begin
        if (e_v && !out_ready && m_stall < CMAX) m_stall++;
        if (out_ready && !e_v && m_bubble < CMAX) m_bubble++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (ox) void'(mq.pop_front());
        if (ix) mq.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, NOP);
    step();
    step();
    nRST = 1'b1;

    // First word appears one cycle after acceptance, then 4 back-to-back.
    drive(1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b0);
    step();
    chk("lat1_valid", {31'd0, out_valid}, 32'd1);
    chk("lat1_data", out_data, 32'h0000_00AA);
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hB0 + i;
      step();
      chk("b2b_data", out_data, 32'hB0 + i);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Stall: third word held upstream, then drained in order.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    #1 chk("stall_rdy0", {31'd0, in_ready}, 32'd1);
    step();
    in_data = 32'h22;
    #1 chk("stall_rdy1", {31'd0, in_ready}, 32'd1);
    step();
    in_data = 32'h33;
    #1 chk("stall_rdy_full", {31'd0, in_ready}, 32'd0);
    step();
    step();
    chk("stall_cnt3", {28'd0, stall_cnt}, 32'd3);
    chk("stall_hold", out_data, 32'h11);
    out_ready = 1'b1;
    step();
    chk("drain_22", out_data, 32'h22);
    chk("drain_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("drain_33", out_data, 32'h33);
    in_valid = 1'b0;
    step();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a concurrent input word.
    drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    step();
    in_data = 32'h55;
    step();
    drive(1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
    #1 chk("flush_rdy", {31'd0, in_ready}, 32'd0);
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data", out_data, NOP);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk("flush_no66", {31'd0, out_valid}, 32'd0);

    // Bubble counter saturation and clear.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    clr_cnt = 1'b0;
    repeat (20) step();
    chk("bubble_sat", {28'd0, bubble_cnt}, 32'hF);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("bubble_clr", {28'd0, bubble_cnt}, 32'd0);

    // Asynchronous reset in the middle of a cycle while FULL.
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    step();
    in_data = 32'h88;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_stall", {28'd0, stall_cnt}, 32'd0);
    chk("arst_data", out_data, NOP);
    chk("arst_rdy", {31'd0, in_ready}, 32'd1);
    step();
    nRST = 1'b1;
    step();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the reference queue.
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
      step();
    end

    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, payload width in bits (one word_t).
REQ-002 SHALL provide parameter NOP_DATA, default 0, bubble payload driven when the stage is empty or flushed.
REQ-003 SHALL provide parameter CNT_W, default 16, width of the performance counters.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept; transfer when in_valid & in_ready.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-011 SHALL have port out_data  output  DATA_W  head payload.
REQ-012 SHALL have port flush  input  1  synchronous squash of stage contents (replaces the old per-stage RST strobe).
REQ-013 SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-014 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid & !out_ready.
REQ-015 SHALL have port bubble_cnt  output  CNT_W  cycles with out_ready & !out_valid.

Function
REQ-016 SHALL hold a two-entry skid buffer, main (head) and skid, with state EMPTY, ONE or FULL.
REQ-017 SHALL drive out_valid = (state != EMPTY) and out_data = main, or NOP_DATA when EMPTY.
REQ-018 SHALL drive in_ready = (state != FULL) & !flush, decoded from registered state plus flush only, with no path from out_ready.
REQ-019 SHALL, in EMPTY: on input transfer, load main and go to ONE; otherwise stay.
REQ-020 SHALL, in ONE: input only -> load skid, go FULL; output only -> EMPTY; both -> load main with in_data, stay ONE; neither -> hold.
REQ-021 SHALL, in FULL: on output transfer, move skid to main and go to ONE; otherwise hold; no input is accepted.
REQ-022 SHALL give latency of exactly one cycle from input transfer to out_valid when the stage was EMPTY, and sustain one transfer per cycle in ONE.
REQ-023 SHALL preserve payload order; no payload is duplicated or dropped except by flush.
REQ-024 SHALL, on flush, take priority over all transfers: next state EMPTY, main and skid <= NOP_DATA; a same-cycle output handshake still completes downstream.
REQ-025 SHALL hold contents unchanged while out_ready is low (stall), equivalent to deasserting the old W enable.
REQ-026 SHALL increment stall_cnt on each cycle with out_valid & !out_ready, and bubble_cnt on each cycle with out_ready & !out_valid, both saturating at all-ones with no wrap.
REQ-027 SHALL zero both counters on clr_cnt, which takes priority over an increment in the same cycle; flush does not clear the counters.

Reset
REQ-028 SHALL, while nRST is low, immediately force state EMPTY, main and skid to NOP_DATA, counters to 0, out_valid 0, out_data NOP_DATA, and in_ready 1 when flush is low.
REQ-029 SHALL discard any in-flight payload on reset mid-operation and resume at the first rising CLK edge after nRST goes high.

Verification
REQ-030 SHALL cover: reset, then in_valid=1 with in_data=0x0000_00AA and out_ready=1 -> out_valid=1 and out_data=0xAA on the next cycle; 4 back-to-back words are delivered in order, one per cycle.
REQ-031 SHALL cover: out_ready=0 while pushing 0x11, 0x22, 0x33 -> in_ready falls after 2 accepts, 0x33 is held upstream, stall_cnt counts; then out_ready=1 -> 0x11, 0x22, 0x33 are delivered in order.
REQ-032 SHALL cover: FULL with flush=1 and in_valid=1 in the same cycle -> in_ready=0, next cycle out_valid=0 and out_data=NOP_DATA, and the input word is never delivered.
REQ-033 SHALL cover: CNT_W=4 with out_ready=1 and no input for 20 cycles -> bubble_cnt saturates at 0xF; a clr_cnt pulse -> 0 on the next cycle.
REQ-034 SHALL cover: nRST asserted mid-cycle in FULL -> out_valid=0 and counters=0 without waiting for a CLK edge.
REQ-035 SHALL cover: random in_valid/out_ready for 10k cycles against a reference queue -> no loss, duplication or reordering, and the stage never holds more than 2 entries.
